// File: rtl/marker_stream_pkg.sv
// Shared types, header layout constants and packet-length helper for the marker stream source.
package marker_stream_pkg;

  // Packet phases: header word, timestamp chunks, fill words.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    TS   = 2'd2,
    FILL = 2'd3
  } state_e;

  // Header word layout: tag in the top byte, sequence number in the remaining low bits.
  localparam int unsigned TAG_W = 8;
  localparam logic [7:0]  MARKER_TAG_DEFAULT = 8'hA5;

  // Effective packet length: at least header plus timestamp, at most the configured ceiling.
  function automatic int unsigned clamp_len(input int unsigned req,
                                            input int unsigned lo,
                                            input int unsigned hi);
    if (req < lo) return lo;
    if (req > hi) return hi;
    return req;
  endfunction

endpackage

// File: rtl/marker_stream_if.sv
// AXI-stream style marker channel between the generator and the DMA path.
// Handshake: a word moves only in a cycle where TVALID and TREADY are both high; once
// TVALID is raised, TDATA/TLAST/TVALID stay unchanged until that transfer happens, and
// TVALID never depends combinationally on TREADY.
interface marker_stream_if #(
  parameter int unsigned AXI_WIDTH = 32
) ();
  logic [AXI_WIDTH-1:0] sysMarkerTDATA;
  logic                 sysMarkerTVALID;
  logic                 sysMarkerTREADY;
  logic                 sysMarkerTLAST;

  modport master (
    output sysMarkerTDATA, sysMarkerTVALID, sysMarkerTLAST,
    input  sysMarkerTREADY
  );

  modport slave (
    input  sysMarkerTDATA, sysMarkerTVALID, sysMarkerTLAST,
    output sysMarkerTREADY
  );
endinterface

// File: rtl/marker_period_timer.sv
// Programmable period timer: one-cycle tick every period_i clocks, restarted whenever
// period_i changes; a period of zero parks the timer.
module marker_period_timer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] period_i,
  output logic        tick_o
);

  logic [31:0] period_q;
  logic [31:0] cnt_q, cnt_d;

  // Next count: reload on a new period, otherwise count down and wrap to period-1.
  always_comb begin
    cnt_d = cnt_q;
    if (period_i != period_q) begin
      cnt_d = (period_i == 32'd0) ? 32'd0 : period_i - 32'd1;
    end else if (period_q != 32'd0) begin
      cnt_d = (cnt_q == 32'd0) ? period_q - 32'd1 : cnt_q - 32'd1;
    end
  end

  // Counter and last-seen period registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      period_q <= 32'd0;
      cnt_q    <= 32'd0;
    end else begin
      period_q <= period_i;
      cnt_q    <= cnt_d;
    end
  end

  // Tick at zero, suppressed in the cycle a new period is being loaded.
  always_comb begin
    tick_o = (period_q != 32'd0) && (period_i == period_q) && (cnt_q == 32'd0);
  end

endmodule

// File: rtl/marker_stream_gen.sv
// Marker packet source: header {tag, seq}, timestamp chunks MS-first, then fill words.
module marker_stream_gen
  import marker_stream_pkg::*;
#(
  parameter int unsigned          SYSCLK_RATE      = 100000000,
  parameter int unsigned          TIMESTAMP_WIDTH  = 64,
  parameter int unsigned          AXI_WIDTH        = 32,
  parameter int unsigned          MAX_PACKET_WORDS = 16,
  parameter logic [7:0]           MARKER_TAG       = MARKER_TAG_DEFAULT,
  parameter logic [AXI_WIDTH-1:0] FILL_WORD        = '1
) (
  input  logic                                  sysClk,
  input  logic                                  sysResetN,
  input  logic                                  sysLogEnable,
  input  logic [TIMESTAMP_WIDTH-1:0]            sysTimestamp,
  input  logic [31:0]                           sysPeriodTicks,
  input  logic [$clog2(MAX_PACKET_WORDS+1)-1:0] sysPacketWords,
  input  logic                                  sysForceMarker,
  marker_stream_if.master                       m_axis,
  output logic [AXI_WIDTH-9:0]                  sysSequence,
  output logic [15:0]                           sysDroppedCount,
  output state_e                                dbg_state_o
);

  localparam int unsigned TSW   = TIMESTAMP_WIDTH / AXI_WIDTH;
  localparam int unsigned PW    = $clog2(MAX_PACKET_WORDS + 1);
  localparam int unsigned SEQ_W = AXI_WIDTH - TAG_W;

  // Reject parameter sets the datapath cannot represent.
  if (AXI_WIDTH < 24 || (TIMESTAMP_WIDTH % AXI_WIDTH) != 0 || SYSCLK_RATE == 0) begin : g_bad_params
    $error("marker_stream_gen: unsupported parameter combination");
  end

  state_e                     state_q, state_d;
  logic [PW-1:0]              len_q, word_q, len_req;
  logic [TIMESTAMP_WIDTH-1:0] ts_sh_q, pend_ts_q;
  logic                       pend_q;
  logic [SEQ_W-1:0]           seq_q;
  logic [15:0]                drop_q;
  logic                       tick, trig, busy, xfer, tlast_w, last_xfer, start_now;
  logic [AXI_WIDTH-1:0]       tdata_w;

  marker_period_timer u_timer (
    .clk_i    (sysClk),
    .rst_ni   (sysResetN),
    .period_i (sysPeriodTicks),
    .tick_o   (tick)
  );

  // Trigger qualification, transfer detection and packet-start decision.
  always_comb begin
    trig      = (tick || sysForceMarker) && sysLogEnable;
    busy      = (state_q != IDLE);
    xfer      = busy && m_axis.sysMarkerTREADY;
    tlast_w   = busy && (word_q == len_q - PW'(1));
    last_xfer = xfer && tlast_w;
    start_now = (!busy && (trig || pend_q)) || (last_xfer && pend_q);
    len_req   = PW'(clamp_len(32'(sysPacketWords), 1 + TSW, MAX_PACKET_WORDS));
  end

  // FSM state register.
  always_ff @(posedge sysClk or negedge sysResetN) begin
    if (!sysResetN) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // FSM next state: a finished packet chains straight into the pending one.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_now) state_d = HDR;
      HDR:  if (xfer) state_d = TS;
      TS: begin
        if (last_xfer)                          state_d = pend_q ? HDR : IDLE;
        else if (xfer && word_q == PW'(TSW))    state_d = FILL;
      end
      FILL: if (last_xfer) state_d = pend_q ? HDR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: stream word chosen by phase; everything is zero while idle.
  always_comb begin
    tdata_w = '0;
    unique case (state_q)
      HDR:     tdata_w = {MARKER_TAG, seq_q};
      TS:      tdata_w = ts_sh_q[TIMESTAMP_WIDTH-1 -: AXI_WIDTH];
      FILL:    tdata_w = FILL_WORD;
      default: tdata_w = '0;
    endcase
  end

  assign m_axis.sysMarkerTDATA  = tdata_w;
  assign m_axis.sysMarkerTVALID = busy;
  assign m_axis.sysMarkerTLAST  = tlast_w;
  assign sysSequence            = seq_q;
  assign sysDroppedCount        = drop_q;
  assign dbg_state_o            = state_q;

  // Packet datapath: latch length and timestamp at start, walk words, bump seq at the end.
  always_ff @(posedge sysClk or negedge sysResetN) begin
    if (!sysResetN) begin
      len_q   <= '0;
      word_q  <= '0;
      ts_sh_q <= '0;
      seq_q   <= '0;
    end else begin
      if (start_now) begin
        len_q   <= len_req;
        word_q  <= '0;
        ts_sh_q <= pend_q ? pend_ts_q : sysTimestamp;
      end else if (xfer) begin
        word_q <= word_q + PW'(1);
        if (state_q == TS) ts_sh_q <= ts_sh_q << AXI_WIDTH;
      end
      if (last_xfer) seq_q <= seq_q + SEQ_W'(1);
    end
  end

  // One-deep trigger backlog; anything beyond it is counted as dropped.
  always_ff @(posedge sysClk or negedge sysResetN) begin
    if (!sysResetN) begin
      pend_q    <= 1'b0;
      pend_ts_q <= '0;
      drop_q    <= '0;
    end else begin
      if (trig && pend_q && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      if (start_now && pend_q) begin
        pend_q <= 1'b0;
      end else if (trig && !pend_q && busy) begin
        pend_q    <= 1'b1;
        pend_ts_q <= sysTimestamp;
      end
    end
  end

endmodule

// File: tb/tb_marker_stream_gen.sv
// Bench for marker_stream_gen: packet-level reference model plus directed scenarios.
module tb_marker_stream_gen;
  import marker_stream_pkg::*;

  // Clock / reset and stimulus signals
  logic        sysClk         = 1'b0;
  logic        sysResetN      = 1'b0;
  logic        sysLogEnable   = 1'b0;
  logic [63:0] sysTimestamp   = 64'd0;
  logic [31:0] sysPeriodTicks = 32'd0;
  logic [4:0]  sysPacketWords = 5'd4;
  logic        sysForceMarker = 1'b0;
  logic        tready         = 1'b1;
  logic [23:0] sysSequence;
  logic [15:0] sysDroppedCount;
  state_e      dbg_state;

  marker_stream_if #(.AXI_WIDTH(32)) m_axis ();
  assign m_axis.sysMarkerTREADY = tready;

  always #5 sysClk = ~sysClk;

  marker_stream_gen dut (
    .sysClk          (sysClk),
    .sysResetN       (sysResetN),
    .sysLogEnable    (sysLogEnable),
    .sysTimestamp    (sysTimestamp),
    .sysPeriodTicks  (sysPeriodTicks),
    .sysPacketWords  (sysPacketWords),
    .sysForceMarker  (sysForceMarker),
    .m_axis          (m_axis),
    .sysSequence     (sysSequence),
    .sysDroppedCount (sysDroppedCount),
    .dbg_state_o     (dbg_state)
  );

  // Scoreboard / reference model state
  int          checks = 0;
  int          errors = 0;
  int          cyc_n  = 0;
  logic [31:0] exp_q[$];
  bit          m_pend;
  logic [63:0] m_pend_ts;
  logic [23:0] m_seq;
  int          m_drop;
  int          m_prev_period;
  int          m_c0;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        last;
  } xfer_t;
  xfer_t log_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ld(input int i);
    return (i < log_q.size()) ? log_q[i].data : 32'hx;
  endfunction

  function automatic logic ll(input int i);
    return (i < log_q.size()) ? log_q[i].last : 1'bx;
  endfunction

  function automatic int lc(input int i);
    return (i < log_q.size()) ? log_q[i].cyc : -1;
  endfunction

  // Build the full word list of one packet from its sequence, timestamp and requested length.
  function automatic void push_packet(input logic [23:0] seq, input logic [63:0] ts, input int req);
    int len;
    len = (req < 3) ? 3 : ((req > 16) ? 16 : req);
    exp_q.push_back({8'hA5, seq});
    exp_q.push_back(ts[63:32]);
    exp_q.push_back(ts[31:0]);
    for (int i = 0; i < len - 3; i++) exp_q.push_back(32'hFFFF_FFFF);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_pend        = 1'b0;
    m_pend_ts     = 64'd0;
    m_seq         = 24'd0;
    m_drop        = 0;
    m_prev_period = 0;
    m_c0          = 0;
  endtask

  // Advance the model by one clock using the inputs present in cycle cyc_n.
  task automatic model_step();
    bit tick, trig, busy, xfer, last, pend0;
    int per;
    if (!sysResetN) begin
      model_reset();
    end else begin
      per = int'(sysPeriodTicks);
      if (per != m_prev_period) begin
        m_c0 = cyc_n;
        tick = 1'b0;
      end else begin
        tick = (per != 0) && (cyc_n > m_c0) && (((cyc_n - m_c0) % per) == 0);
      end
      m_prev_period = per;
      trig  = (tick || sysForceMarker) && sysLogEnable;
      busy  = (exp_q.size() != 0);
      xfer  = busy && tready;
      last  = xfer && (exp_q.size() == 1);
      pend0 = m_pend;
      if (xfer) void'(exp_q.pop_front());
      if (last) m_seq = m_seq + 24'd1;
      if (trig && pend0) begin
        if (m_drop < 65535) m_drop++;
      end else if (trig && busy) begin
        m_pend    = 1'b1;
        m_pend_ts = sysTimestamp;
      end
      if ((!busy || last) && pend0) begin
        push_packet(m_seq, m_pend_ts, int'(sysPacketWords));
        m_pend = 1'b0;
      end else if (!busy && trig) begin
        push_packet(m_seq, sysTimestamp, int'(sysPacketWords));
      end
    end
  endtask

  // One clock: compare outputs mid-cycle, log transfers, step the model, return after the edge.
  task automatic cyc();
    @(negedge sysClk);
    check("tvalid",  64'(m_axis.sysMarkerTVALID), 64'(exp_q.size() != 0));
    check("tdata",   64'(m_axis.sysMarkerTDATA),  64'((exp_q.size() != 0) ? exp_q[0] : 32'h0));
    check("tlast",   64'(m_axis.sysMarkerTLAST),  64'(exp_q.size() == 1));
    check("seq",     64'(sysSequence),            64'(m_seq));
    check("dropped", 64'(sysDroppedCount),        64'(m_drop));
    if (m_axis.sysMarkerTVALID && tready)
      log_q.push_back('{cyc_n, m_axis.sysMarkerTDATA, m_axis.sysMarkerTLAST});
    model_step();
    cyc_n++;
    @(posedge sysClk);
    #1;
  endtask

  task automatic force_pulse();
    sysForceMarker = 1'b1;
    cyc();
    sysForceMarker = 1'b0;
  endtask

  int t1_c0;

  initial begin
    model_reset();

    // Reset state
    repeat (3) cyc();
    check("rst_state",   64'(dbg_state), 64'(IDLE));
    check("rst_tvalid",  64'(m_axis.sysMarkerTVALID), 64'd0);
    check("rst_tdata",   64'(m_axis.sysMarkerTDATA), 64'd0);
    check("rst_seq",     64'(sysSequence), 64'd0);
    check("rst_dropped", 64'(sysDroppedCount), 64'd0);
    sysResetN = 1'b1;
    cyc();

    // Periodic markers: period 10, four-word packets
    log_q.delete();
    sysTimestamp   = 64'h0000_0001_0000_0002;
    sysPacketWords = 5'd4;
    sysLogEnable   = 1'b1;
    tready         = 1'b1;
    sysPeriodTicks = 32'd10;
    t1_c0          = cyc_n;
    repeat (25) cyc();
    sysPeriodTicks = 32'd0;
    check("p1_count", 64'(log_q.size()), 64'd8);
    check("p1_w0", 64'(ld(0)), 64'hA500_0000);
    check("p1_w1", 64'(ld(1)), 64'h0000_0001);
    check("p1_w2", 64'(ld(2)), 64'h0000_0002);
    check("p1_w3", 64'(ld(3)), 64'hFFFF_FFFF);
    check("p1_last2", 64'(ll(2)), 64'd0);
    check("p1_last3", 64'(ll(3)), 64'd1);
    check("p1_hdr2", 64'(ld(4)), 64'hA500_0001);
    check("p1_latency", 64'(lc(0)), 64'(t1_c0 + 11));
    check("p1_spacing", 64'(lc(4) - lc(0)), 64'd10);
    cyc();

    // Length clamping: 1 -> 3 words, 31 -> 16 words
    log_q.delete();
    sysTimestamp   = 64'hDEAD_BEEF_0123_4567;
    sysPacketWords = 5'd1;
    force_pulse();
    repeat (8) cyc();
    check("clamp_lo_count", 64'(log_q.size()), 64'd3);
    check("clamp_lo_hdr",   64'(ld(0)), 64'hA500_0002);
    check("clamp_lo_w2",    64'(ld(2)), 64'h0123_4567);
    check("clamp_lo_last",  64'(ll(2)), 64'd1);
    log_q.delete();
    sysPacketWords = 5'd31;
    force_pulse();
    repeat (20) cyc();
    check("clamp_hi_count", 64'(log_q.size()), 64'd16);
    check("clamp_hi_w15",   64'(ld(15)), 64'hFFFF_FFFF);
    check("clamp_hi_last14", 64'(ll(14)), 64'd0);
    check("clamp_hi_last15", 64'(ll(15)), 64'd1);

    // Back-pressure: TREADY toggling every cycle
    log_q.delete();
    sysTimestamp   = 64'h1111_2222_3333_4444;
    sysPacketWords = 5'd6;
    tready         = 1'b0;
    force_pulse();
    for (int i = 0; i < 20; i++) begin
      tready = i[0];
      cyc();
    end
    tready = 1'b1;
    cyc();
    check("bp_count", 64'(log_q.size()), 64'd6);
    check("bp_hdr",   64'(ld(0)), 64'hA500_0004);
    check("bp_ts_hi", 64'(ld(1)), 64'h1111_2222);
    check("bp_ts_lo", 64'(ld(2)), 64'h3333_4444);
    check("bp_last",  64'(ll(5)), 64'd1);
    check("bp_seq",   64'(sysSequence), 64'd5);

    // Stalled stream: one in flight, one pending, two dropped
    log_q.delete();
    sysPacketWords = 5'd4;
    tready         = 1'b0;
    for (int i = 0; i < 15; i++) begin
      sysForceMarker = (i == 0 || i == 5 || i == 8 || i == 11);
      cyc();
    end
    sysForceMarker = 1'b0;
    check("stall_dropped", 64'(sysDroppedCount), 64'd2);
    check("stall_tvalid",  64'(m_axis.sysMarkerTVALID), 64'd1);
    tready = 1'b1;
    repeat (10) cyc();
    check("b2b_count", 64'(log_q.size()), 64'd8);
    check("b2b_hdr0",  64'(ld(0)), 64'hA500_0005);
    check("b2b_hdr1",  64'(ld(4)), 64'hA500_0006);
    check("b2b_gap",   64'(lc(7) - lc(0)), 64'd7);

    // Logging disabled: no triggers accepted
    log_q.delete();
    sysLogEnable   = 1'b0;
    sysPeriodTicks = 32'd5;
    for (int i = 0; i < 50; i++) begin
      sysForceMarker = ((i % 7) == 3);
      cyc();
    end
    sysForceMarker = 1'b0;
    sysPeriodTicks = 32'd0;
    cyc();
    check("dis_count",   64'(log_q.size()), 64'd0);
    check("dis_seq",     64'(sysSequence), 64'd7);
    check("dis_dropped", 64'(sysDroppedCount), 64'd2);

    // Enable dropped mid-packet: packet still completes
    log_q.delete();
    sysLogEnable   = 1'b1;
    sysPacketWords = 5'd5;
    force_pulse();
    repeat (2) cyc();
    sysLogEnable = 1'b0;
    repeat (8) cyc();
    check("en_drop_count", 64'(log_q.size()), 64'd5);
    check("en_drop_last",  64'(ll(4)), 64'd1);
    check("en_drop_seq",   64'(sysSequence), 64'd8);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) sysPeriodTicks = 32'($urandom_range(0, 12));
      sysLogEnable   = ($urandom_range(0, 9) != 0);
      sysForceMarker = ($urandom_range(0, 15) == 0);
      tready         = ($urandom_range(0, 2) != 0);
      sysPacketWords = 5'($urandom_range(0, 31));
      sysTimestamp   = {$urandom, $urandom};
      cyc();
    end
    sysPeriodTicks = 32'd0;
    sysForceMarker = 1'b0;
    tready         = 1'b1;
    repeat (40) cyc();

    // Asynchronous reset in the middle of a packet
    sysLogEnable   = 1'b1;
    sysPacketWords = 5'd8;
    sysTimestamp   = 64'hCAFE_0000_BEEF_0001;
    force_pulse();
    repeat (2) cyc();
    check("pre_rst_word2", 64'(m_axis.sysMarkerTDATA), 64'hBEEF_0001);
    #2;
    sysResetN = 1'b0;
    #1;
    check("async_tvalid", 64'(m_axis.sysMarkerTVALID), 64'd0);
    check("async_tlast",  64'(m_axis.sysMarkerTLAST), 64'd0);
    check("async_tdata",  64'(m_axis.sysMarkerTDATA), 64'd0);
    model_reset();
    repeat (3) cyc();
    sysResetN = 1'b1;
    cyc();
    log_q.delete();
    force_pulse();
    repeat (12) cyc();
    check("post_rst_count",   64'(log_q.size()), 64'd8);
    check("post_rst_hdr",     64'(ld(0)), 64'hA500_0000);
    check("post_rst_dropped", 64'(sysDroppedCount), 64'd0);
    check("post_rst_seq",     64'(sysSequence), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
